float_divider: RTL and testbench

Iterative IEEE-754 single-precision divider, z = a / b, with a valid/ready handshake on both sides. It is the inverse companion to the team's combinational float multiplier. It uses the same operand unpacking, denormal treatment, round-to-nearest-even and special-value encodings, so the two blocks can sit side by side in the arithmetic test suite. It trades throughput for area: one quotient bit per cycle, one operation in flight.

---
 rtl/float_divider_pkg.sv | 24 ++
 rtl/float_unpack.sv | 34 +++
 rtl/float_divider.sv | 233 +++++++++++++++++++++++
 tb/tb_float_divider.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/float_divider_pkg.sv
// rtl/float_divider_pkg.sv - binary32 constants, exponent type and divider state encoding
package float_divider_pkg;

  typedef logic signed [9:0] exp_t;

  localparam exp_t BIAS = 10'sd127;
  localparam exp_t EMIN = -10'sd126;
  localparam exp_t EMAX = 10'sd127;
  localparam logic [30:0] QNAN = 31'h7FC00000;
  localparam logic [30:0] INF  = 31'h7F800000;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_UNPACK    = 4'd1,
    ST_NORMALISE = 4'd2,
    ST_DIVIDE    = 4'd3,
    ST_ALIGN     = 4'd4,
    ST_DENORM    = 4'd5,
    ST_ROUND     = 4'd6,
    ST_PACK      = 4'd7,
    ST_OUTPUT    = 4'd8
  } state_e;

endpackage

// File: rtl/float_unpack.sv
// rtl/float_unpack.sv - combinational binary32 field split with special-value flags
module float_unpack
  import float_divider_pkg::*;
(
  input  logic [31:0] word,
  output logic        sign,
  output exp_t        exp_u,
  output logic [23:0] mant,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic [7:0]  field;
  logic [22:0] frac;

  always_comb begin
    field   = word[30:23];
    frac    = word[22:0];
    sign    = word[31];
    is_zero = (field == 8'd0) && (frac == 23'd0);
    is_inf  = (field == 8'hFF) && (frac == 23'd0);
    is_nan  = (field == 8'hFF) && (frac != 23'd0);
    // Denormals share the smallest normal exponent with a zero hidden bit.
    if (field == 8'd0) begin
      exp_u = EMIN;
      mant  = {1'b0, frac};
    end else begin
      exp_u = $signed({2'b00, field}) - BIAS;
      mant  = {1'b1, frac};
    end
  end

endmodule

// File: rtl/float_divider.sv
// rtl/float_divider.sv - iterative binary32 divider, one quotient bit per cycle
module float_divider
  import float_divider_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] z
);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic        zs_q, zs_d, special_q, special_d;
  exp_t        ae_q, ae_d, be_q, be_d, ze_q, ze_d;
  logic [23:0] am_q, am_d, bm_q, bm_d, m_q, m_d;
  logic [26:0] q_q, q_d;
  logic [24:0] r_q, r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        g_q, g_d, rd_q, rd_d, st_q, st_d;

  logic        ua_sign, ub_sign, ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan;
  exp_t        ua_exp, ub_exp;
  logic [23:0] ua_mant, ub_mant;

  float_unpack u_unpack_a (
    .word(a_q), .sign(ua_sign), .exp_u(ua_exp), .mant(ua_mant),
    .is_zero(ua_zero), .is_inf(ua_inf), .is_nan(ua_nan)
  );

  float_unpack u_unpack_b (
    .word(b_q), .sign(ub_sign), .exp_u(ub_exp), .mant(ub_mant),
    .is_zero(ub_zero), .is_inf(ub_inf), .is_nan(ub_nan)
  );

  logic [24:0] rem;
  logic        q_bit;
  exp_t        ze_calc;
  exp_t        ef;
  logic [24:0] rsum;
  logic        inc;
  logic        zs_w;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    zs_d      = zs_q;
    special_d = special_q;
    ae_d      = ae_q;
    be_d      = be_q;
    ze_d      = ze_q;
    am_d      = am_q;
    bm_d      = bm_q;
    m_d       = m_q;
    q_d       = q_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    g_d       = g_q;
    rd_d      = rd_q;
    st_d      = st_q;
    rem       = r_q;
    q_bit     = 1'b0;
    ze_calc   = ze_q;
    ef        = ze_q + BIAS;
    rsum      = {1'b0, m_q};
    inc       = 1'b0;
    zs_w      = ua_sign ^ ub_sign;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        zs_d      = zs_w;
        ae_d      = ua_exp;
        be_d      = ub_exp;
        am_d      = ua_mant;
        bm_d      = ub_mant;
        special_d = 1'b1;
        if (ua_nan || ub_nan || (ua_zero && ub_zero) || (ua_inf && ub_inf))
          z_d = {zs_w, QNAN};
        else if (ua_inf || ub_zero)
          z_d = {zs_w, INF};
        else if (ua_zero || ub_inf)
          z_d = {zs_w, 31'd0};
        else
          special_d = 1'b0;
        // Special results pass through PACK so they surface two cycles after accept.
        state_d = special_d ? ST_PACK : ST_NORMALISE;
      end
      ST_NORMALISE: begin
        if (!am_q[23]) begin
          am_d = {am_q[22:0], 1'b0};
          ae_d = ae_q - 10'sd1;
        end else if (!bm_q[23]) begin
          bm_d = {bm_q[22:0], 1'b0};
          be_d = be_q - 10'sd1;
        end else begin
          r_d     = {1'b0, am_q};
          q_d     = 27'd0;
          cnt_d   = 5'd0;
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (r_q >= {1'b0, bm_q}) begin
          rem   = r_q - {1'b0, bm_q};
          q_bit = 1'b1;
        end
        // rem < bm < 2^24 here, so the shift never drops a set bit.
        r_d   = {rem[23:0], 1'b0};
        q_d   = {q_q[25:0], q_bit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd26) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (q_q[26]) begin
          m_d     = q_q[26:3];
          g_d     = q_q[2];
          rd_d    = q_q[1];
          st_d    = q_q[0] | (r_q != 25'd0);
          ze_calc = ae_q - be_q;
        end else begin
          m_d     = q_q[25:2];
          g_d     = q_q[1];
          rd_d    = q_q[0];
          st_d    = (r_q != 25'd0);
          ze_calc = ae_q - be_q - 10'sd1;
        end
        ze_d    = ze_calc;
        cnt_d   = 5'd0;
        state_d = (ze_calc < EMIN) ? ST_DENORM : ST_ROUND;
      end
      ST_DENORM: begin
        m_d   = {1'b0, m_q[23:1]};
        g_d   = m_q[0];
        rd_d  = g_q;
        st_d  = st_q | rd_q;
        ze_d  = ze_q + 10'sd1;
        cnt_d = cnt_q + 5'd1;
        if ((ze_d == EMIN) || (cnt_q == 5'd25)) begin
          ze_d    = EMIN;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        inc  = g_q & (rd_q | st_q | m_q[0]);
        rsum = {1'b0, m_q} + {24'd0, inc};
        if (rsum[24]) begin
          m_d  = 24'h800000;
          ze_d = ze_q + 10'sd1;
        end else begin
          m_d = rsum[23:0];
        end
        state_d = ST_PACK;
      end
      ST_PACK: begin
        if (!special_q) begin
          if (ze_q > EMAX)
            z_d = {zs_q, INF};
          else if (m_q == 24'd0)
            z_d = {zs_q, 31'd0};
          else if ((ze_q == EMIN) && !m_q[23])
            z_d = {zs_q, 8'd0, m_q[22:0]};
          else
            z_d = {zs_q, ef[7:0], m_q[22:0]};
        end
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      z_q       <= 32'd0;
      zs_q      <= 1'b0;
      special_q <= 1'b0;
      ae_q      <= '0;
      be_q      <= '0;
      ze_q      <= '0;
      am_q      <= 24'd0;
      bm_q      <= 24'd0;
      m_q       <= 24'd0;
      q_q       <= 27'd0;
      r_q       <= 25'd0;
      cnt_q     <= 5'd0;
      g_q       <= 1'b0;
      rd_q      <= 1'b0;
      st_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      z_q       <= z_d;
      zs_q      <= zs_d;
      special_q <= special_d;
      ae_q      <= ae_d;
      be_q      <= be_d;
      ze_q      <= ze_d;
      am_q      <= am_d;
      bm_q      <= bm_d;
      m_q       <= m_d;
      q_q       <= q_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      g_q       <= g_d;
      rd_q      <= rd_d;
      st_q      <= st_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUTPUT);
  assign z         = z_q;

endmodule

// File: tb/tb_float_divider.sv
// tb/tb_float_divider.sv - directed scoreboard bench for float_divider
module tb_float_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] expz;
  int lat;

  float_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drives operands and returns just after the accept edge.
  task automatic send_op(input logic [31:0] av, input logic [31:0] bv);
    int budget;
    a = av;
    b = bv;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 200) begin
      tick();
      budget++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pop_check(input string tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      expz = sb.pop_front();
      check({tag, "_z"}, z, expz);
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ez, input int elat);
    int l;
    sb.push_back(ez);
    send_op(av, bv);
    wait_out(l);
    check({tag, "_latency"}, l, elat);
    pop_check(tag);
    tick();
    check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_z", z, 32'd0);
    rst = 1'b0;
    tick();

    do_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 32);
    do_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32);
    do_op("neg_third", 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 32);
    do_op("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 2);
    do_op("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 2);
    do_op("inf_inf", 32'hFF800000, 32'h7F800000, 32'hFFC00000, 2);
    do_op("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 32);
    do_op("denorm_out", 32'h00800000, 32'h40000000, 32'h00400000, 33);
    do_op("min_denorm", 32'h00000001, 32'h3F800000, 32'h00000001, 78);

    // Backpressure: output held while a competing request waits.
    out_ready = 1'b0;
    sb.push_back(32'h40400000);
    send_op(32'h40C00000, 32'h40000000);
    wait_out(lat);
    check("bp_latency", lat, 32);
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_z_stable", z, sb[0]);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    pop_check("bp");
    out_ready = 1'b1;
    tick();
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    sb.push_back(32'h3EAAAAAB);
    tick();
    in_valid = 1'b0;
    check("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    check("bp_next_latency", lat, 32);
    pop_check("bp_next");
    tick();

    // Reset ten cycles into DIVIDE aborts the operation.
    send_op(32'h3F800000, 32'h40400000);
    for (int i = 0; i < 12; i++) tick();
    check("mid_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_z", z, 32'd0);
    do_op("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 32);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
